// File: rtl/mem_bank.sv
// mem_bank: single-port word memory with byte addressing, power-up clear pass and 1-cycle registered reads.
// Ports: CLK/RST (async active-high reset), REQ/WE/A/D/BE request side,
//        READY (accepting), Q/QV (read data + valid pulse), ERR (error pulse).
// Macro MEM_BANK_BE_EN: when defined, BE selects the written bytes; otherwise writes cover the full word.
module mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                REQ,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   A,
  input  logic [DATA_W-1:0]   D,
  input  logic [DATA_W/8-1:0] BE,
  output logic                READY,
  output logic [DATA_W-1:0]   Q,
  output logic                QV,
  output logic                ERR
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] IDLE  = 1'b1;

  logic [0:0]        r_state;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic              r_qv, r_err;

  logic [ADDR_W-1:0] w_word;
  logic [IDX_W-1:0]  w_idx;
  logic [BYTES-1:0]  w_be;
  logic              w_bad, w_acc, w_wr, w_rd, w_clr;

  assign w_word = A >> OFF_W;
  assign w_idx  = w_word[IDX_W-1:0];
  // misaligned offset or word index beyond the array
  assign w_bad  = (|(A & ADDR_W'(BYTES - 1))) | (w_word >= ADDR_W'(DEPTH));
  assign w_clr  = r_state == CLEAR;
  assign w_acc  = REQ & READY;
  assign w_wr   = w_acc & WE & ~w_bad;
  assign w_rd   = w_acc & ~WE & ~w_bad;
`ifdef MEM_BANK_BE_EN
  assign w_be   = BE;
`else
  // BE is folded in only to keep the port referenced; the result is all ones
  assign w_be   = {BYTES{1'b1}} | BE;
`endif

  assign READY = r_state == IDLE;
  assign Q     = r_q;
  assign QV    = r_qv;
  assign ERR   = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else if (w_clr) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      r_state   <= (r_clr_cnt == IDX_W'(DEPTH - 1)) ? IDLE : CLEAR;
    end
  end

  // the array has no reset; the clear pass zeroes it after every reset
  always_ff @(posedge CLK) begin
    if (w_clr)
      r_mem[r_clr_cnt] <= '0;
    else if (w_wr)
      for (int b = 0; b < BYTES; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= D[8*b +: 8];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q   <= '0;
      r_qv  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_qv  <= w_rd;
      r_err <= w_acc & w_bad;
      if (w_rd) r_q <= r_mem[w_idx];
    end
  end
endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: directed table-driven checks of mem_bank with DEPTH=16, DATA_W=32.
module tb_mem_bank;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 32;
`ifdef MEM_BANK_BE_EN
  localparam logic [31:0] PART = 32'hDEAD3344;
`else
  localparam logic [31:0] PART = 32'h11223344;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ = 1'b0;
  logic          WE  = 1'b0;
  logic [AW-1:0] A   = '0;
  logic [DW-1:0] D   = '0;
  logic [3:0]    BE  = '0;
  logic          READY, QV, ERR;
  logic [DW-1:0] Q;

  int n_run = 0;
  int n_fail = 0;

  mem_bank #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .A(A), .D(D), .BE(BE),
    .READY(READY), .Q(Q), .QV(QV), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        qv;
    logic        err;
    logic [31:0] q;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    REQ = r; WE = w; A = a; D = d; BE = be;
  endtask

  // release reset at a negedge and count negedges until READY rises
  task automatic release_and_count(input string name);
    int n;
    n = 0;
    RST = 1'b0;
    while (!READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk(name, 32'(n), 32'(DP));
  endtask

  task automatic read_one(input logic [31:0] a, input string name, input logic [31:0] exp);
    @(negedge CLK);
    drive(1, 0, a, 0, 0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    chk({name, "_qv"}, 32'(QV), 32'd1);
    chk({name, "_q"}, Q, exp);
  endtask

  initial begin
    tbl[0]  = '{0, 32'h00, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[1]  = '{0, 32'h3C, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[2]  = '{1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
    tbl[3]  = '{0, 32'h08, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 32'h08, 32'h11223344, 4'h3, 0, 0, 32'hDEADBEEF};
    tbl[5]  = '{0, 32'h08, 32'h0,        4'h0, 1, 0, PART};
    tbl[6]  = '{0, 32'h06, 32'h0,        4'h0, 0, 1, PART};
    tbl[7]  = '{0, 32'h40, 32'h0,        4'h0, 0, 1, PART};
    tbl[8]  = '{1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, 1, PART};
    tbl[9]  = '{1, 32'h02, 32'hFFFFFFFF, 4'hF, 0, 1, PART};
    tbl[10] = '{0, 32'h00, 32'h0,        4'h0, 1, 0, 32'h0};
    tbl[11] = '{0, 32'h08, 32'h0,        4'h0, 1, 0, PART};
    tbl[12] = '{1, 32'h3C, 32'hA5A5C3C3, 4'hF, 0, 0, PART};
    tbl[13] = '{0, 32'h3C, 32'h0,        4'h0, 1, 0, 32'hA5A5C3C3};

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(READY), 0);
    chk("rst_qv", 32'(QV), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_q", Q, 0);
    drive(1, 0, 0, 0, 0);
    release_and_count("clear_len");
    drive(0, 0, 0, 0, 0);
    chk("busy_req_ignored", 32'(QV | ERR), 0);

    for (int i = 0; i <= DP; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        chk($sformatf("zero%0d_qv", i - 1), 32'(QV), 1);
        chk($sformatf("zero%0d_q", i - 1), Q, 0);
      end
      if (i < DP) drive(1, 0, 32'(i * 4), 0, 0); else drive(0, 0, 0, 0, 0);
    end

    for (int i = 0; i <= 14; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        chk($sformatf("v%0d_qv", i - 1), 32'(QV), 32'(tbl[i-1].qv));
        chk($sformatf("v%0d_err", i - 1), 32'(ERR), 32'(tbl[i-1].err));
        chk($sformatf("v%0d_q", i - 1), Q, tbl[i-1].q);
      end
      if (i < 14) drive(1, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be);
      else drive(0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(1, 1, 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);
    end
    for (int i = 0; i <= 4; i++) begin
      @(negedge CLK);
      if (i > 0) begin
        chk($sformatf("b2b%0d_qv", i - 1), 32'(QV), 1);
        chk($sformatf("b2b%0d_q", i - 1), Q, 32'hC0DE0000 + 32'(i - 1));
      end
      if (i < 4) drive(1, 0, 32'(i * 4), 0, 0); else drive(0, 0, 0, 0, 0);
    end
    @(negedge CLK);
    chk("idle_qv", 32'(QV), 0);
    chk("idle_q_hold", Q, 32'hC0DE0003);

    RST = 1'b1;
    @(negedge CLK);
    chk("rst2_q", Q, 0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("midclr_ready", 32'(READY), 0);
    #2 RST = 1'b1;
    @(negedge CLK);
    release_and_count("reclear_len");
    read_one(32'h4, "reclear_w1", 0);

    @(negedge CLK);
    drive(1, 1, 32'h8, 32'h12345678, 4'hF);
    @(negedge CLK);
    drive(1, 0, 32'h8, 0, 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rd_abort_qv", 32'(QV), 0);
    chk("rd_abort_q", Q, 0);
    release_and_count("rd_abort_clear_len");
    read_one(32'h8, "rd_abort_w2", 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits; legal values are 8, 16, 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words; legal values are powers of two ≥ 2.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port CLK, input, 1 bit; single clock, all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port REQ, input, 1 bit; access request.
REQ-007 SHALL have port WE, input, 1 bit; 1 = write, 0 = read; sampled with REQ.
REQ-008 SHALL have port A, input, ADDR_W bits; byte address.
REQ-009 SHALL have port D, input, DATA_W bits; write data.
REQ-010 SHALL have port BE, input, DATA_W/8 bits; byte enables, bit i covers D[8i+7:8i].
REQ-011 SHALL have port READY, output, 1 bit; block accepts requests.
REQ-012 SHALL have port Q, output, DATA_W bits; registered read data.
REQ-013 SHALL have port QV, output, 1 bit; Q valid, one-cycle pulse.
REQ-014 SHALL have port ERR, output, 1 bit; access error, one-cycle pulse.

Function
REQ-015 SHALL implement two states: CLEAR and IDLE.
REQ-016 In CLEAR, SHALL write zero to word clr_cnt each cycle, from 0 to DEPTH-1, while holding READY=0.
REQ-017 SHALL go from CLEAR to IDLE on the cycle that clears word DEPTH-1, so READY=1 from the following cycle; the clear takes exactly DEPTH cycles after RST falls.
REQ-018 SHALL accept a request only on a cycle with REQ=1 and READY=1; REQ while READY=0 SHALL be ignored and produce no response.
REQ-019 SHALL form the word index as A >> log2(DATA_W/8); the low log2(DATA_W/8) bits are the offset.
REQ-020 An accepted access SHALL be an error when the offset is nonzero or the index is ≥ DEPTH.
REQ-021 An accepted error access SHALL leave memory unchanged, pulse ERR=1 on the next cycle, and hold QV=0 and Q.
REQ-022 An accepted legal write SHALL update, on the same edge, exactly the bytes whose BE bit is 1; it SHALL produce neither QV nor ERR.
REQ-023 An accepted legal read SHALL present mem[index] on Q with QV=1 on the next cycle; read latency is exactly 1 cycle.
REQ-024 SHALL accept back-to-back requests every cycle at full throughput.
REQ-025 A read accepted the cycle after a write to the same word SHALL return the post-write data.
REQ-026 When QV=0, Q SHALL hold its last value.

Reset
REQ-027 While RST=1: READY=0, QV=0, ERR=0, Q=0, clr_cnt=0, state=CLEAR.
REQ-028 RST asserted mid-operation SHALL immediately drop any pending response, abort any clear in progress, and restart CLEAR from word 0 after release.
REQ-029 Memory contents are not reset directly; the post-reset CLEAR pass zeroes them.

Configuration
REQ-030 Macro MEM_BANK_BE_EN: when defined, BE SHALL act as specified in REQ-022.
REQ-031 When MEM_BANK_BE_EN is undefined, BE SHALL be ignored and every legal write SHALL update the full word.

Verification
REQ-032 RST pulse, DEPTH=16 -> READY=0 for exactly 16 cycles after release, then 1; reads of indices 0..15 return 0.
REQ-033 Write A=0x8, D=0xDEADBEEF, BE=0xF, then the next cycle read A=0x8 -> next cycle Q=0xDEADBEEF, QV=1.
REQ-034 With MEM_BANK_BE_EN defined: write A=0x8, D=0x11223344, BE=0x3 over 0xDEADBEEF, then read -> Q=0xDEAD3344. Without the macro, the same sequence -> Q=0x11223344.
REQ-035 Read A=0x6, then read A=DEPTH*4 -> ERR=1 one cycle after each request, QV=0, Q unchanged, memory unchanged.
REQ-036 Four back-to-back reads, A=0x0,0x4,0x8,0xC -> four consecutive QV pulses returning data in request order.
REQ-037 RST asserted mid-CLEAR and again the cycle after a read is accepted -> no QV follows; CLEAR restarts and READY rises DEPTH cycles after release.
